// File: rtl/aes_pkg.sv
// Shared AES types, constants and byte/state transforms used by the encrypt and decrypt cores.
// State byte s[r][c] lives at bits [127-8*(4c+r) -: 8] (column-major, s0,0 in the top byte).
package aes_pkg;

  parameter int unsigned AesRounds = 10;

  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  word_t;
  typedef logic [127:0] state_t;

  typedef enum logic [0:0] {StIdle, StRound} aes_fsm_e;

  parameter byte_t RconInit = 8'h01;

  function automatic byte_t xtime(byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic byte_t gf_mul(byte_t a, byte_t b);
    byte_t p;
    byte_t x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254; maps 0 to 0 as the S-box requires.
  function automatic byte_t gf_inv(byte_t x);
    byte_t x3, x7, x15, x31, x63, x127;
    x3   = gf_mul(gf_mul(x, x), x);
    x7   = gf_mul(gf_mul(x3, x3), x);
    x15  = gf_mul(gf_mul(x7, x7), x);
    x31  = gf_mul(gf_mul(x15, x15), x);
    x63  = gf_mul(gf_mul(x31, x31), x);
    x127 = gf_mul(gf_mul(x63, x63), x);
    return gf_mul(x127, x127);
  endfunction

  function automatic state_t shift_rows(state_t s);
    state_t o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic state_t mix_columns(state_t s);
    state_t o;
    byte_t a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box: GF(2^8) inverse followed by the affine transform.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  byte_t inv;

  assign inv   = gf_inv(in_i);
  assign out_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
                 {inv[3:0], inv[7:4]} ^ 8'h63;

endmodule

// File: rtl/aes_encryption_iter.sv
// Iterative AES-128 encryption: one round per clock with the key schedule expanded on the fly.
module aes_encryption_iter
  import aes_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = AesRounds
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] data,
  input  logic [127:0] key,
  output logic [127:0] cipher,
  output logic         done,
  output logic         busy
);

  aes_fsm_e   fsm_q;
  state_t     state_q, key_q, cipher_q;
  byte_t      rcon_q;
  logic [3:0] round_q;
  logic       done_q, busy_q;

  state_t sub_state, shifted, mid_state, last_state, next_key;
  word_t  ks_rot, ks_sub, ks_temp;
  word_t  nw0, nw1, nw2, nw3;

  for (genvar i = 0; i < 16; i++) begin : g_sub_bytes
    aes_sbox u_sbox (
      .in_i  (state_q[8*i +: 8]),
      .out_o (sub_state[8*i +: 8])
    );
  end

  // RotWord on w3 (the low word of the round key), then SubWord.
  assign ks_rot = {key_q[23:0], key_q[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_key_sbox
    aes_sbox u_sbox (
      .in_i  (ks_rot[8*i +: 8]),
      .out_o (ks_sub[8*i +: 8])
    );
  end

  assign ks_temp  = ks_sub ^ {rcon_q, 24'h000000};
  assign nw0      = key_q[127:96] ^ ks_temp;
  assign nw1      = key_q[95:64] ^ nw0;
  assign nw2      = key_q[63:32] ^ nw1;
  assign nw3      = key_q[31:0] ^ nw2;
  assign next_key = {nw0, nw1, nw2, nw3};

  assign shifted    = shift_rows(sub_state);
  assign mid_state  = mix_columns(shifted) ^ next_key;
  assign last_state = shifted ^ next_key;

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q    <= StIdle;
      state_q  <= '0;
      key_q    <= '0;
      cipher_q <= '0;
      rcon_q   <= RconInit;
      round_q  <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (fsm_q)
        StIdle: begin
          if (start) begin
            state_q <= data ^ key;
            key_q   <= key;
            rcon_q  <= RconInit;
            round_q <= 4'd1;
            busy_q  <= 1'b1;
            fsm_q   <= StRound;
          end
        end
        StRound: begin
          key_q   <= next_key;
          rcon_q  <= xtime(rcon_q);
          round_q <= round_q + 4'd1;
          if (round_q == 4'(NUM_ROUNDS)) begin
            state_q  <= last_state;
            cipher_q <= last_state;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            round_q  <= '0;
            fsm_q    <= StIdle;
          end else begin
            state_q <= mid_state;
          end
        end
        default: fsm_q <= StIdle;
      endcase
    end
  end

  assign cipher = cipher_q;
  assign done   = done_q;
  assign busy   = busy_q;

endmodule
